// File: rtl/quad_pkg.sv
// Shared types and Gray-code helpers for the quadrature step decoder.
// Forward rotation walks 00 > 01 > 11 > 10 > 00 on {a,b}.
package quad_pkg;

  typedef logic [1:0] phase_t;

  typedef enum logic {
    SEED,
    TRACK
  } dec_state_t;

  typedef enum logic [1:0] {
    NONE,
    FWD,
    REV,
    ILLEGAL
  } dir_t;

  localparam phase_t SEQ0 = 2'b00;
  localparam phase_t SEQ1 = 2'b01;
  localparam phase_t SEQ2 = 2'b11;
  localparam phase_t SEQ3 = 2'b10;

  function automatic phase_t next_fwd(input phase_t p);
    phase_t n;
    case (p)
      SEQ0:    n = SEQ1;
      SEQ1:    n = SEQ2;
      SEQ2:    n = SEQ3;
      default: n = SEQ0;
    endcase
    return n;
  endfunction

  function automatic dir_t quad_dir(input phase_t o, input phase_t n);
    dir_t d;
    if (o == n)
      d = NONE;
    else if (next_fwd(o) == n)
      d = FWD;
    else if (next_fwd(n) == o)
      d = REV;
    else
      d = ILLEGAL;
    return d;
  endfunction

endpackage

// File: rtl/debounce_filter.sv
// Joint stability filter: a W-bit value is accepted once it has
// held for DEBOUNCE cycles after its first change.
module debounce_filter #(
  parameter int W        = 2,
  parameter int DEBOUNCE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] s_i,
  output logic [W-1:0] val_o,
  output logic         accept_o
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

  logic [W-1:0]  prev_q;
  logic [W-1:0]  val_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          hold;
  logic          accept;

  assign hold   = (s_i == prev_q) && (s_i != val_q);
  assign accept = hold && (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = '0;
    if (hold && !accept)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
      val_q  <= '0;
      cnt_q  <= '0;
    end else begin
      prev_q <= s_i;
      cnt_q  <= cnt_d;
      if (accept)
        val_q <= s_i;
    end
  end

  assign val_o    = val_q;
  assign accept_o = accept;

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature encoder front-end: sync, debounce, Gray decode and
// detent accumulation into one-cycle step strobes with direction.
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int DETENT      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a,
  input  logic       b,
  output logic       en,
  output logic       down,
  output logic       err,
  output logic [1:0] phase
);

  localparam int AW = $clog2(DETENT) + 2;
  localparam int SW = $clog2(DEBOUNCE + 1);
  localparam logic signed [AW-1:0] DET_P = AW'(DETENT);
  localparam logic signed [AW-1:0] DET_N = -DET_P;
  localparam logic [SW-1:0] SEED_MAX = SW'(DEBOUNCE - 1);

  logic [SYNC_STAGES-1:0] a_sync_q;
  logic [SYNC_STAGES-1:0] b_sync_q;
  phase_t                 s;
  phase_t                 phase_w;
  logic                   accept;
  dir_t                   dir;
  dec_state_t             state_q;
  logic [SW-1:0]          seed_cnt_q;
  logic signed [AW-1:0]   acc_q;
  logic signed [AW-1:0]   acc_d;
  logic                   en_q;
  logic                   down_q;
  logic                   err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sync_q <= '0;
      b_sync_q <= '0;
    end else begin
      a_sync_q <= {a_sync_q[SYNC_STAGES-2:0], a};
      b_sync_q <= {b_sync_q[SYNC_STAGES-2:0], b};
    end
  end

  assign s = {a_sync_q[SYNC_STAGES-1], b_sync_q[SYNC_STAGES-1]};

  debounce_filter #(
    .W        (2),
    .DEBOUNCE (DEBOUNCE)
  ) u_filter (
    .clk      (clk),
    .rst      (rst),
    .s_i      (s),
    .val_o    (phase_w),
    .accept_o (accept)
  );

  assign dir = quad_dir(phase_w, s);

  always_comb begin
    acc_d = acc_q;
    case (dir)
      FWD:     acc_d = acc_q + AW'(1);
      REV:     acc_d = acc_q - AW'(1);
      default: acc_d = acc_q;
    endcase
  end

  // SEED leaves on its first accept without judging it, or once s has sat on phase long enough
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SEED;
      seed_cnt_q <= '0;
      acc_q      <= '0;
      en_q       <= 1'b0;
      down_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      en_q  <= 1'b0;
      err_q <= 1'b0;
      unique case (state_q)
        SEED: begin
          if (accept) begin
            state_q    <= TRACK;
            seed_cnt_q <= '0;
          end else if (s == phase_w) begin
            if (seed_cnt_q == SEED_MAX)
              state_q <= TRACK;
            else
              seed_cnt_q <= seed_cnt_q + 1'b1;
          end else begin
            seed_cnt_q <= '0;
          end
        end
        TRACK: begin
          if (accept) begin
            if (dir == ILLEGAL) begin
              err_q <= 1'b1;
              acc_q <= '0;
            end else if (acc_d == DET_P) begin
              en_q   <= 1'b1;
              down_q <= 1'b0;
              acc_q  <= '0;
            end else if (acc_d == DET_N) begin
              en_q   <= 1'b1;
              down_q <= 1'b1;
              acc_q  <= '0;
            end else begin
              acc_q <= acc_d;
            end
          end
        end
      endcase
    end
  end

  assign en    = en_q;
  assign down  = down_q;
  assign err   = err_q;
  assign phase = phase_w;

endmodule
